// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states and architectural constants.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, FULL, DRAIN, FAULT
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one request at a time to imem,
// and holds the returned word for the decoder until it is accepted.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  fetch_state_t    r_state, w_nxt_state;
  logic [XLEN-1:0] r_pc, w_nxt_pc;
  logic [XLEN-1:0] r_inst, r_inst_pc;
  logic            r_fault;
  logic            w_load, w_fault_set;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_load      = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      IDLE:  w_nxt_state = FETCH;
      FETCH: if (imem_req_ready) w_nxt_state = WAIT;
      WAIT: if (imem_rsp_valid) begin
        w_nxt_state = FULL;
        w_load      = 1'b1;
        w_nxt_pc    = r_pc + 32'd4;
      end
      FULL:  if (inst_ready) w_nxt_state = FETCH;
      DRAIN: if (imem_rsp_valid) w_nxt_state = FETCH;
      default: ;
    endcase

    // Redirect overrides everything; any in-flight response gets drained.
    if (redirect && r_state != FAULT) begin
      w_nxt_pc = redirect_pc;
      w_load   = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        w_nxt_state = FAULT;
        w_fault_set = 1'b1;
      end else begin
        case (r_state)
          FETCH:   w_nxt_state = imem_req_ready ? DRAIN : FETCH;
          WAIT:    w_nxt_state = imem_rsp_valid ? FETCH : DRAIN;
          DRAIN:   w_nxt_state = DRAIN;
          default: w_nxt_state = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_inst    <= NOP_INST;
      r_inst_pc <= RESET_PC;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      if (w_load) begin
        r_inst    <= imem_rsp_data;
        r_inst_pc <= r_pc;
      end
      if (w_fault_set) r_fault <= 1'b1;
    end
  end

  // A faulting pc may be misaligned; the request address stays word-aligned.
  assign imem_req_valid = (r_state == FETCH);
  assign imem_req_addr  = {r_pc[XLEN-1:2], 2'b00};
  assign inst_valid     = (r_state == FULL);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected requests/instructions are queued and
// popped by a monitor whenever the DUT completes a handshake.
module tb_inst_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  int pass = 0;
  int tot  = 0;
  logic [31:0] q_req[$];
  logic [31:0] q_inst[$];
  logic [31:0] q_ipc[$];
  logic [31:0] hold_inst, hold_pc;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : {a[15:0], 16'h0513};
  endfunction

  // 1-cycle memory, reset together with the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      imem_rsp_valid <= imem_req_valid && imem_req_ready;
      imem_rsp_data  <= mem_word(imem_req_addr);
    end
  end

  always @(posedge clk)
    if (rst_n && imem_rsp_valid)
      assert (dut.r_state == WAIT || dut.r_state == DRAIN)
        else $error("response outside WAIT/DRAIN");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic monitor();
    if (imem_req_valid && imem_req_ready) begin
      if (q_req.size() == 0) begin
        tot++;
        $display("FAIL unexpected_req: got %h expected none", imem_req_addr);
      end else chk("req_addr", imem_req_addr, q_req.pop_front());
    end
    if (inst_valid && inst_ready) begin
      if (q_inst.size() == 0) begin
        tot++;
        $display("FAIL unexpected_inst: got %h expected none", inst);
      end else begin
        chk("inst", inst, q_inst.pop_front());
        chk("inst_pc", inst_pc, q_ipc.pop_front());
      end
    end
  endtask

  // Inputs are set at a negedge; step samples the cycle and moves to the next negedge.
  task automatic step();
    #3;
    monitor();
    @(negedge clk);
  endtask

  task automatic exp_inst(input logic [31:0] d, input logic [31:0] pc);
    q_inst.push_back(d);
    q_ipc.push_back(pc);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0000_0100);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Boot fetch from RESET_PC
    rst_n = 1'b1;
    q_req.push_back(32'h0000_0100);
    step();                                   // IDLE -> FETCH
    chk("boot_req_valid", {31'b0, imem_req_valid}, 32'd1);
    step();                                   // accepted -> WAIT
    step();                                   // response -> FULL
    chk("boot_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("boot_inst", inst, 32'h0050_0093);
    chk("boot_inst_pc", inst_pc, 32'h0000_0100);

    // Back-pressure: hold stays stable, no new request
    hold_inst = inst;
    hold_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst", inst, hold_inst);
      chk("stall_pc", inst_pc, hold_pc);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    exp_inst(32'h0050_0093, 32'h0000_0100);
    q_req.push_back(32'h0000_0104);
    step();                                   // FULL -> FETCH
    inst_ready = 1'b0;
    chk("next_req_addr", imem_req_addr, 32'h0000_0104);

    // Redirect while request 0x104 is accepted -> drain
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    q_req.push_back(32'h0000_0200);
    chk("drain_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();                                   // stale response dropped
    chk("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("drain_req_addr", imem_req_addr, 32'h0000_0200);
    step();
    step();
    chk("r200_inst", inst, 32'h0200_0513);
    chk("r200_inst_pc", inst_pc, 32'h0000_0200);

    // Redirect in FULL without inst_ready
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    chk("full_redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("full_redir_addr", imem_req_addr, 32'h0000_0300);
    q_req.push_back(32'h0000_0300);
    step();
    step();
    exp_inst(32'h0300_0513, 32'h0000_0300);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Redirect in FETCH while memory stalls, then wrap past the top
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    chk("stall_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    q_req.push_back(32'hFFFF_FFFC);
    step();
    step();
    exp_inst(32'hFFFC_0513, 32'hFFFF_FFFC);
    q_req.push_back(32'h0000_0000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);
    step();
    step();
    chk("wrap_inst_pc", inst_pc, 32'h0000_0000);

    // Misaligned redirect -> sticky fault
    redirect = 1'b1;
    redirect_pc = 32'h0000_0202;
    step();
    redirect = 1'b0;
    chk("fault_set", {31'b0, fetch_fault}, 32'd1);
    chk("fault_inst_valid", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
      end else redirect = 1'b0;
      step();
      chk("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    redirect = 1'b0;

    // Async reset clears fault; fetch restarts at RESET_PC
    rst_n = 1'b0;
    #1;
    chk("areset_fault", {31'b0, fetch_fault}, 32'd0);
    chk("areset_inst", inst, 32'h0000_0013);
    step();
    rst_n = 1'b1;
    q_req.push_back(32'h0000_0100);
    step();
    step();
    step();
    exp_inst(32'h0050_0093, 32'h0000_0100);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    chk("req_q_empty", q_req.size(), 32'd0);
    chk("inst_q_empty", q_inst.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake. It holds each returned instruction word, with its PC, in an output register until the decoder side accepts it. Redirects for branches and jumps are honoured in any state, and responses that are still in flight from before a redirect are discarded.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  byte address of the request; always word-aligned.
- imem_req_ready  in  1  memory accepts the request on a cycle where valid and ready are both high.
- imem_rsp_valid  in  1  response valid; one cycle per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  inst and inst_pc hold an instruction.
- inst  out  32  instruction word to the decoder.
- inst_pc  out  32  address that inst came from.
- inst_ready  in  1  consumer accepts inst this cycle.
- redirect  in  1  one-cycle pulse: continue fetching at redirect_pc.
- redirect_pc  in  32  redirect target.
- fetch_fault  out  1  sticky flag: a misaligned redirect occurred.

## Operation
- States: IDLE, FETCH, WAIT, FULL, DRAIN, FAULT. At most one request is outstanding.
- Reset values:
  - state = IDLE, pc = RESET_PC.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - inst_valid = 0, inst = 32'h0000_0013 (NOP), inst_pc = RESET_PC.
  - fetch_fault = 0.
- State behaviour (when no redirect is present):
  - IDLE: go to FETCH unconditionally.
  - FETCH: drive imem_req_valid = 1 and imem_req_addr = pc. When imem_req_ready = 1, go to WAIT.
  - WAIT: when imem_rsp_valid = 1, latch inst = imem_rsp_data and inst_pc = pc, set pc = pc+4, and go to FULL.
  - FULL: drive inst_valid = 1. When inst_ready = 1, go to FETCH.
  - DRAIN: when imem_rsp_valid = 1, discard the data and go to FETCH.
  - FAULT: imem_req_valid = 0 and inst_valid = 0. Leave only through reset.
- inst and inst_pc stay stable while inst_valid = 1 and inst_ready = 0.
- PC arithmetic: 32-bit, modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Redirect (takes priority over all normal transitions):
  - Sets pc = redirect_pc, except in FAULT, where it is ignored.
  - If redirect_pc[1:0] != 0: set fetch_fault = 1 and go to FAULT.
  - In FETCH, if the request is accepted in the same cycle: go to DRAIN, because the old-address response is still pending.
  - In FETCH, if the request is not accepted: stay in FETCH; the next request uses the new pc.
  - In WAIT without imem_rsp_valid: go to DRAIN.
  - In WAIT with imem_rsp_valid in the same cycle: discard the data and go to FETCH.
  - In FULL: drop the held instruction (inst_valid = 0 from the next cycle) and go to FETCH. This applies whether or not inst_ready is high.
  - In DRAIN: update pc and stay in DRAIN.
  - In IDLE: update pc and go to FETCH.
- An imem_rsp_valid outside WAIT/DRAIN is a protocol violation. It is ignored and flagged by a bench assertion.
- Reset asserted mid-operation: all state returns to reset values immediately. An outstanding memory response after reset release is not tracked; the memory model is reset together with this block.

## Timing
- Reset release: the first rising edge moves IDLE to FETCH, so imem_req_valid first goes high 1 cycle after release.
- Best case (imem_req_ready = 1, response 1 cycle after acceptance, inst_ready = 1):
  - request in cycle n, response in cycle n+1, inst_valid in cycle n+2, next request in cycle n+3.
  - Steady-state throughput is one instruction per 3 cycles.
- Redirect affects imem_req_addr from the cycle after the pulse.
- inst_valid deasserts the cycle after a redirect in FULL.
- fetch_fault rises the cycle after a misaligned redirect.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Shared package core_pkg holds:
  - the fetch_state_t enum (IDLE, FETCH, WAIT, FULL, DRAIN, FAULT);
  - the NOP_INST constant 32'h0000_0013;
  - the XLEN = 32 constant.
- Single module, no sub-module: pc register, FSM and output holding register in one block.

## Test plan
- Reset with RESET_PC = 32'h0000_0100, ready = 1, 1-cycle memory returning 32'h0050_0093 -> request addr 0x100 at release+1; inst = 32'h0050_0093 with inst_pc = 0x100 two cycles later; next request addr 0x104.
- inst_ready held 0 for 5 cycles in FULL -> inst and inst_pc stable, no new request. Raise inst_ready -> FETCH request at pc+4 the next cycle.
- Redirect to 0x200 in the same cycle a request at 0x104 is accepted -> DRAIN; the 0x104 response is dropped with inst_valid staying 0; the next request is at 0x200.
- Redirect to 0x300 in FULL with inst_ready = 0 -> inst_valid = 0 the next cycle; request at 0x300.
- Redirect to 32'hFFFF_FFFC, then let the first fetch complete -> the following request address is 0x0000_0000.
- Redirect to 0x202 -> fetch_fault = 1 the next cycle, imem_req_valid = 0 thereafter; rst_n pulse -> fetch_fault = 0 and fetching resumes at RESET_PC.
